// File: rtl/main_bus_pkg.sv
// Shared definitions for the main-bus driver/receiver pair: default widths and
// the receiver FSM state encoding.
package main_bus_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_SETTLE = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_WAIT_LOW
    } rx_state_e;

endpackage

// File: rtl/main_bus_receiver_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is only
// accepted when a pop frees a slot in the same cycle.
module rx_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    // NOTE: storage has no reset; validity lives entirely in r_count, so resetting
    // the array would only add reset fan-out without changing behaviour.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/main_bus_receiver.sv
// Samples main_bus once per read_state pulse after a settle delay and queues the
// value for the CPU; a sticky flag records values dropped on a full queue.
module main_bus_receiver
    import main_bus_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic             myclk,
    input  logic             reset_n,
    input  logic             read_state,
    input  logic [WIDTH-1:0] main_bus,
    output logic [WIDTH-1:0] cpu_data,
    output logic             cpu_valid,
    input  logic             cpu_ready,
    output logic             overflow,
    input  logic             ovf_clear,
    output logic             busy
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic             r_rs_q;
    logic             r_rs_prev;
    logic [WIDTH-1:0] r_mb_q;
    rx_state_e        r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_overflow;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, which the rs_q -> rs_prev chain relies on.
    always_ff @(posedge myclk) begin
        if (!reset_n) begin
            r_rs_q    <= 1'b0;
            r_rs_prev <= 1'b0;
            r_mb_q    <= '0;
        end else begin
            r_rs_q    <= read_state;
            r_rs_prev <= r_rs_q;
            r_mb_q    <= main_bus;
        end
    end

    always_ff @(posedge myclk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_rs_q && !r_rs_prev) begin
                        r_state <= ST_SETTLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    // A pulse that ends before the settle time expires is ignored.
                    if (!r_rs_q) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CW'(SETTLE - 1)) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_CAPTURE: begin
                    r_state <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    if (!r_rs_q) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_push = (r_state == ST_CAPTURE);
    assign w_pop  = !w_empty && cpu_ready;
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge myclk) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clear) begin
            r_overflow <= 1'b0;
        end
    end

    rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (myclk),
        .i_rst_n (reset_n),
        .i_push  (w_push),
        .i_data  (r_mb_q),
        .i_pop   (w_pop),
        .o_head  (cpu_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign cpu_valid = !w_empty;
    assign overflow  = r_overflow;
    assign busy      = r_busy;

endmodule

// File: tb/tb_main_bus_receiver.sv
// Directed bench for main_bus_receiver (WIDTH=4, DEPTH=4, SETTLE=2); expected
// values are hand-derived from the read-pulse timing and FIFO rules.
module tb_main_bus_receiver;

    logic       myclk = 1'b0;
    logic       reset_n;
    logic       read_state;
    logic [3:0] main_bus;
    logic [3:0] cpu_data;
    logic       cpu_valid;
    logic       cpu_ready;
    logic       overflow;
    logic       ovf_clear;
    logic       busy;

    int total = 0;
    int bad   = 0;

    main_bus_receiver #(
        .WIDTH  (4),
        .DEPTH  (4),
        .SETTLE (2)
    ) dut (
        .myclk      (myclk),
        .reset_n    (reset_n),
        .read_state (read_state),
        .main_bus   (main_bus),
        .cpu_data   (cpu_data),
        .cpu_valid  (cpu_valid),
        .cpu_ready  (cpu_ready),
        .overflow   (overflow),
        .ovf_clear  (ovf_clear),
        .busy       (busy)
    );

    always #5 myclk = ~myclk;

    // Advance one edge; inputs and outputs are both handled 1 time unit after it.
    task automatic cycle();
        @(posedge myclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
            $error("check %s", tag);
        end
    endtask

    // read_state high for len edges (N..N+len-1); capture edge is N+4 for SETTLE=2.
    task automatic pulse(input logic [3:0] v, input int len, input logic rdy_at_cap,
                         input logic clr_at_cap);
        read_state = 1'b1;
        main_bus   = v;
        for (int i = 0; i < 4; i++) begin
            if (i == len) read_state = 1'b0;
            cycle();
        end
        read_state = 1'b0;
        cpu_ready  = rdy_at_cap;
        ovf_clear  = clr_at_cap;
        cycle();
        cpu_ready  = 1'b0;
        ovf_clear  = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic pop();
        cpu_ready = 1'b1;
        cycle();
        cpu_ready = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        read_state = 1'b0;
        main_bus   = 4'h0;
        cpu_ready  = 1'b0;
        ovf_clear  = 1'b0;
        cycle();
        cycle();
        check("rst_valid", cpu_valid, 0);
        check("rst_data",  cpu_data,  0);
        check("rst_ovf",   overflow,  0);
        check("rst_busy",  busy,      0);
        reset_n = 1'b1;
        cycle();

        // Basic 4-cycle pulse with 0xA: valid rises after edge N+4.
        read_state = 1'b1;
        main_bus   = 4'hA;
        cycle();                                  // N
        check("t1_busy_n", busy, 0);
        cycle();                                  // N+1
        check("t1_busy_settle", busy, 1);
        cycle();                                  // N+2
        cycle();                                  // N+3
        check("t1_valid_early", cpu_valid, 0);
        read_state = 1'b0;
        cycle();                                  // N+4
        check("t1_valid", cpu_valid, 1);
        check("t1_data",  cpu_data,  4'hA);
        pop();                                    // N+5
        check("t1_valid_pop", cpu_valid, 0);
        check("t1_busy_idle", busy, 0);
        cycle();

        // Bus changes during the pulse: the value at edge N+3 (5) is captured once.
        read_state = 1'b1;
        main_bus   = 4'h3;
        repeat (3) cycle();                       // N..N+2
        main_bus = 4'h5;
        cycle();                                  // N+3
        main_bus = 4'h9;
        repeat (7) cycle();                       // N+4..N+10
        check("t2_busy_wait", busy, 1);
        read_state = 1'b0;
        repeat (3) cycle();
        check("t2_busy_idle", busy, 0);
        check("t2_valid", cpu_valid, 1);
        check("t2_data",  cpu_data,  4'h5);
        pop();
        check("t2_single", cpu_valid, 0);

        // Too-short pulse is aborted.
        pulse(4'h7, 2, 1'b0, 1'b0);
        cycle();
        check("t3_valid", cpu_valid, 0);
        check("t3_busy",  busy,      0);
        check("t3_ovf",   overflow,  0);

        // Five captures into a 4-deep FIFO: the fifth is dropped.
        for (int i = 1; i <= 4; i++) pulse(4'(i), 4, 1'b0, 1'b0);
        check("t4_ovf_full", overflow, 0);
        pulse(4'h5, 4, 1'b0, 1'b0);
        check("t4_ovf", overflow, 1);
        for (int i = 1; i <= 4; i++) begin
            check("t4_drain_valid", cpu_valid, 1);
            check("t4_drain_data",  cpu_data,  4'(i));
            pop();
        end
        check("t4_empty", cpu_valid, 0);
        check("t4_ovf_sticky", overflow, 1);
        ovf_clear = 1'b1;
        cycle();
        ovf_clear = 1'b0;
        check("t4_ovf_clr", overflow, 0);

        // Full FIFO with a pop on the capture edge: both succeed, no overflow.
        for (int i = 1; i <= 4; i++) pulse(4'(i), 4, 1'b0, 1'b0);
        pulse(4'h6, 4, 1'b1, 1'b0);
        check("t5_ovf_pp", overflow, 0);
        check("t5_head",   cpu_data, 4'h2);
        pulse(4'h7, 4, 1'b0, 1'b0);
        check("t5_ovf_drop", overflow, 1);
        pulse(4'h8, 4, 1'b0, 1'b1);
        check("t5_set_wins", overflow, 1);
        ovf_clear = 1'b1;
        cycle();
        ovf_clear = 1'b0;
        check("t5_ovf_clr", overflow, 0);
        check("t5_d0", cpu_data, 4'h2);
        pop();
        check("t5_d1", cpu_data, 4'h3);
        pop();
        check("t5_d2", cpu_data, 4'h4);
        pop();
        check("t5_d3", cpu_data, 4'h6);
        pop();
        check("t5_empty", cpu_valid, 0);

        // Reset during SETTLE with two entries queued and overflow set.
        for (int i = 1; i <= 5; i++) pulse(4'(i), 4, 1'b0, 1'b0);
        pop();
        pop();
        check("t6_pre_data", cpu_data, 4'h3);
        check("t6_pre_ovf",  overflow, 1);
        read_state = 1'b1;
        main_bus   = 4'hC;
        cycle();                                  // N
        cycle();                                  // N+1
        check("t6_pre_busy", busy, 1);
        reset_n    = 1'b0;
        read_state = 1'b0;
        cycle();
        reset_n = 1'b1;
        check("t6_valid", cpu_valid, 0);
        check("t6_data",  cpu_data,  0);
        check("t6_busy",  busy,      0);
        check("t6_ovf",   overflow,  0);
        repeat (4) cycle();
        check("t6_no_capture", cpu_valid, 0);
        pulse(4'h9, 4, 1'b0, 1'b0);
        check("t6_fresh_data", cpu_data, 4'h9);
        pop();
        check("t6_fresh_empty", cpu_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
